// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: a bus-visible data/status register pair
// feeding a circular FIFO that drains into an 8N1 serial framer.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] DATA_ADDR    = 32'h000fffff,
  parameter logic [31:0] STAT_ADDR    = 32'h000ffffb
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  we_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full;
  logic          push, pop;

  logic          hit_data, hit_stat, claim;
  logic          push_pend;
  logic [7:0]    push_char;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{wdata_i[23:0], we_i[2:0]};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign hit_data   = (addr_i == DATA_ADDR);
  assign hit_stat   = (addr_i == STAT_ADDR);

  // Blocking on !ready_o keeps a held request from being acknowledged twice;
  // full is judged on the registered count, so a same-cycle pop cannot unstall.
  assign claim = valid_i && !ready_o &&
                 ((hit_data && !(we_i[3] && fifo_full)) || (hit_stat && !hit_data));

  assign push  = ready_o && push_pend;
  assign pop   = (state == IDLE) && !fifo_empty;
  assign irq_o = fifo_empty && (state == IDLE);

  always_comb begin
    status       = '0;
    status[0]    = fifo_empty;
    status[1]    = fifo_full;
    status[2]    = (state != IDLE);
    status[15:8] = 8'(count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_o   <= 1'b0;
      rdata_o   <= '0;
      push_pend <= 1'b0;
      push_char <= '0;
    end else begin
      ready_o   <= claim;
      push_pend <= claim && hit_data && we_i[3];
      rdata_o   <= (claim && hit_stat && !hit_data) ? status : '0;
      if (claim) push_char <= wdata_i[31:24];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (pop) begin
          shift_next = mem[rd_ptr];
          state_next = START;
          baud_next  = '0;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 1'b1;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          state_next = IDLE;
          baud_next  = '0;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Line level follows the upcoming state so tx_o stays aligned with it.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      tx_o    <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: bus timing, framing, FIFO stall, reset abort.
module tb_uart_tx_mmio;

  localparam int CPB = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] DATA_A = 32'h000fffff;
  localparam logic [31:0] STAT_A = 32'h000ffffb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  we = '0;
  logic        ready, tx, irq;
  logic [31:0] rdata;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  rx_q[$];
  logic        rx_busy = 1'b0;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_i(valid), .ready_o(ready), .addr_i(addr),
    .wdata_i(wdata), .we_i(we), .rdata_o(rdata), .tx_o(tx), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: samples each bit mid-cell on falling clock edges.
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      rx_busy = 1'b1;
      repeat (6) @(negedge clk);
      b[0] = tx;
      for (int i = 1; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      rx_q.push_back(b);
      rx_busy = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                     output logic [31:0] rd, output int ack, output int waits);
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = d; we = w;
    waits = 0;
    @(negedge clk);
    while (!ready && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    check("ack_seen", 32'(ready), 32'd1);
    rd  = rdata;
    ack = cyc;
    @(negedge clk);
    check("ack_single", 32'(ready), 32'd0);
    valid = 1'b0; we = '0;
  endtask

  task automatic check_frame(input logic [7:0] b, input int start);
    logic e;
    check("frame_not_late", 32'(cyc <= start), 32'd1);
    while (cyc < start) @(negedge clk);
    check("irq_in_frame", 32'(irq), 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       e = 1'b0;
      else if (i < 36) e = b[(i - 4) / 4];
      else             e = 1'b1;
      check($sformatf("frame_tx_%0d", i), 32'(tx), 32'(e));
      @(negedge clk);
    end
    check("tx_after_frame", 32'(tx), 32'd1);
    check("irq_after_frame", 32'(irq), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(irq && !rx_busy) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("drain_idle", 32'(irq && !rx_busy), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int ack, ack0, w;
    logic seen_ready, seen_low;

    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single frame and exact latency.
    bus(DATA_A, 32'hA5000000, 4'b1000, rd, ack, w);
    check("wr_rdata", rd, 32'd0);
    check_frame(8'hA5, ack + 2);
    check("rx1_size", 32'(rx_q.size()), 32'd1);
    check("rx1_byte", 32'(rx_q[0]), 32'hA5);
    rx_q.delete();

    // Unmapped address is ignored.
    valid = 1'b1; addr = 32'h00001000; wdata = 32'h55000000; we = 4'b1000;
    seen_ready = 1'b0; seen_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready) seen_ready = 1'b1;
      if (!tx) seen_low = 1'b1;
    end
    valid = 1'b0; we = '0;
    check("unmapped_ready", 32'(seen_ready), 32'd0);
    check("unmapped_tx", 32'(seen_low), 32'd0);
    bus(STAT_A, 32'h0, 4'b0000, rd, ack, w);
    check("unmapped_status", rd, 32'h00000001);

    // Data address without byte-3 enable.
    bus(DATA_A, 32'h77000000, 4'b0001, rd, ack, w);
    check("nowe_rdata", rd, 32'd0);
    seen_low = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!tx) seen_low = 1'b1;
    end
    check("nowe_tx", 32'(seen_low), 32'd0);
    bus(STAT_A, 32'h0, 4'b1111, rd, ack, w);
    check("nowe_status", rd, 32'h00000001);

    // Status while transmitting with one queued.
    bus(DATA_A, 32'h11000000, 4'b1000, rd, ack, w);
    bus(DATA_A, 32'h22000000, 4'b1000, rd, ack, w);
    bus(STAT_A, 32'h0, 4'b0000, rd, ack, w);
    check("busy_status", rd, 32'h00000104);
    wait_idle();
    check("rx2_size", 32'(rx_q.size()), 32'd2);
    check("rx2_b0", 32'(rx_q[0]), 32'h11);
    check("rx2_b1", 32'(rx_q[1]), 32'h22);
    rx_q.delete();

    // Full FIFO stall: one in the shifter, eight queued, ninth waits for a pop.
    bus(DATA_A, 32'h55000000, 4'b1000, rd, ack0, w);
    for (int k = 1; k <= 9; k++) begin
      logic [31:0] d;
      d = 32'(k) << 24;
      bus(DATA_A, d, 4'b1000, rd, ack, w);
      if (k < 9) check($sformatf("fill_wait_%0d", k), 32'(w), 32'd0);
      else       check("stall_release_cycle", 32'(ack - ack0), 32'd44);
    end
    wait_idle();
    check("rx9_size", 32'(rx_q.size()), 32'd10);
    check("rx9_b0", 32'(rx_q[0]), 32'h55);
    for (int k = 1; k <= 9; k++)
      check($sformatf("rx9_b%0d", k), 32'(rx_q[k]), 32'(k));
    rx_q.delete();

    // Reset mid-frame during data bit 3 with three characters queued.
    bus(DATA_A, 32'hF0000000, 4'b1000, rd, ack0, w);
    bus(DATA_A, 32'hA1000000, 4'b1000, rd, ack, w);
    bus(DATA_A, 32'hA2000000, 4'b1000, rd, ack, w);
    bus(DATA_A, 32'hA3000000, 4'b1000, rd, ack, w);
    while (cyc < ack0 + 19) @(negedge clk);
    check("bit3_low", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_irq", 32'(irq), 32'd1);
    check("abort_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    bus(STAT_A, 32'h0, 4'b0000, rd, ack, w);
    check("abort_status", rd, 32'h00000001);
    w = 0;
    while (rx_busy && w < 100) begin
      w++;
      @(negedge clk);
    end
    rx_q.delete();
    seen_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx) seen_low = 1'b1;
    end
    check("abort_no_frames", 32'(seen_low), 32'd0);
    check("abort_rx_empty", 32'(rx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
